// File: rtl/arbitro_memoria_pkg.sv
// Shared definitions for the two-master data-memory arbiter: FSM encodings,
// default widths and a small port-mask helper.
package arbitro_defs;

   localparam int DATA_W_DEF     = 32;
   localparam int ADDR_W_DEF     = 6;
   localparam int MEM_ADDR_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } estado_t;

   // One-hot mask {port1, port0} for a selected port index.
   function automatic logic [1:0] port_mask(input logic sel);
      return sel ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/arbitro_memoria_rr.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// on a conflict the port that was not served last wins.
module rr_arbitro2 (
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_last,
   output logic o_any,
   output logic o_winner
);

   always_comb begin
      o_any    = i_req0 | i_req1;
      o_winner = 1'b0;
      if (i_req0 && i_req1) begin
         o_winner = ~i_last;
      end else if (i_req1) begin
         o_winner = 1'b1;
      end
   end

endmodule

// File: rtl/arbitro_memoria.sv
// Arbiter/sequencer that serializes two masters onto the single-port data
// memory; every memory input and every read result is driven from a register.
module arbitro_memoria
   import arbitro_defs::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int MEM_ADDR_W = MEM_ADDR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_W-1:0]     addr0,
   input  logic [ADDR_W-1:0]     addr1,
   input  logic [DATA_W-1:0]     wdata0,
   input  logic [DATA_W-1:0]     wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_W-1:0]     rdata,
   output logic [DATA_W-1:0]     mem_dato,
   output logic [MEM_ADDR_W-1:0] mem_direccion,
   output logic                  mem_sel,
   input  logic [DATA_W-1:0]     mem_salida
);

   estado_t             r_state;
   estado_t             w_state_next;
   logic                r_owner;
   logic                w_owner_next;
   logic                r_last;
   logic                w_last_next;
   logic                r_we;
   logic                w_we_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   w_addr_next;
   logic [DATA_W-1:0]   r_dato;
   logic [DATA_W-1:0]   w_dato_next;
   logic [DATA_W-1:0]   r_rdata;
   logic [DATA_W-1:0]   w_rdata_next;
   logic [1:0]          r_gnt;
   logic [1:0]          w_gnt_next;
   logic [1:0]          r_rvalid;
   logic [1:0]          w_rvalid_next;
   logic                r_sel;
   logic                w_sel_next;

   logic                w_any;
   logic                w_winner;
   logic                w_win_we;
   logic [ADDR_W-1:0]   w_win_addr;
   logic [DATA_W-1:0]   w_win_data;

   rr_arbitro2 u_rr (
      .i_req0   (req0),
      .i_req1   (req1),
      .i_last   (r_last),
      .o_any    (w_any),
      .o_winner (w_winner)
   );

   assign w_win_we   = w_winner ? we1    : we0;
   assign w_win_addr = w_winner ? addr1  : addr0;
   assign w_win_data = w_winner ? wdata1 : wdata0;

   // Next-state and next-output logic; gnt, rvalid and mem_sel are pulses,
   // so they default to zero and are raised only for the cycle they belong to.
   always_comb begin
      w_state_next  = r_state;
      w_owner_next  = r_owner;
      w_last_next   = r_last;
      w_we_next     = r_we;
      w_addr_next   = r_addr;
      w_dato_next   = r_dato;
      w_rdata_next  = r_rdata;
      w_gnt_next    = 2'b00;
      w_rvalid_next = 2'b00;
      w_sel_next    = 1'b0;

      case (r_state)
         IDLE, RESP: begin
            if (w_any) begin
               w_state_next = ACCESS;
               w_owner_next = w_winner;
               w_last_next  = w_winner;
               w_we_next    = w_win_we;
               w_addr_next  = w_win_addr;
               w_dato_next  = w_win_data;
               w_gnt_next   = port_mask(w_winner);
               w_sel_next   = w_win_we;
            end else begin
               w_state_next = IDLE;
            end
         end
         ACCESS: begin
            w_state_next = RESP;
            if (!r_we) begin
               w_rdata_next  = mem_salida;
               w_rvalid_next = port_mask(r_owner);
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_owner  <= 1'b0;
         r_last   <= 1'b1;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_dato   <= '0;
         r_rdata  <= '0;
         r_gnt    <= 2'b00;
         r_rvalid <= 2'b00;
         r_sel    <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_owner  <= w_owner_next;
         r_last   <= w_last_next;
         r_we     <= w_we_next;
         r_addr   <= w_addr_next;
         r_dato   <= w_dato_next;
         r_rdata  <= w_rdata_next;
         r_gnt    <= w_gnt_next;
         r_rvalid <= w_rvalid_next;
         r_sel    <= w_sel_next;
      end
   end

   assign gnt0          = r_gnt[0];
   assign gnt1          = r_gnt[1];
   assign rvalid0       = r_rvalid[0];
   assign rvalid1       = r_rvalid[1];
   assign rdata         = r_rdata;
   assign mem_dato      = r_dato;
   assign mem_sel       = r_sel;
   assign mem_direccion = {{(MEM_ADDR_W-ADDR_W){1'b0}}, r_addr};

endmodule

// File: doc/arbitro_memoria.md
# arbitro_memoria

Two-requester arbiter and sequencer for the shared 64×32 single-port data memory. Accepts independent read/write requests from two masters (port 0: CPU datapath, port 1: loader/debug master) and serializes them onto the memory's data/address/write-select port with round-robin fairness. Sits directly between the masters and the memory. It registers every memory input and every read result, so the memory's combinational write and read paths see clean, single-cycle, stable values.

## Interface
Parameters:
- DATA_W, 32, data width of memory words and request write data
- ADDR_W, 6, request word-address width (64 words)
- MEM_ADDR_W, 32, memory address port width; upper bits driven zero

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0 / req1  in  1  request valid, held until matching gnt
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  ADDR_W  word address; stable while req high
- wdata0 / wdata1  in  DATA_W  write data; stable while req high
- gnt0 / gnt1  out  1  one-cycle pulse: request consumed
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata holds this port's read result
- rdata  out  DATA_W  shared read-result bus, meaningful only with an rvalid
- mem_dato  out  DATA_W  to memory data input
- mem_direccion  out  MEM_ADDR_W  to memory address, {zeros, addr}
- mem_sel  out  1  to memory write select (1 write, 0 read)
- mem_salida  in  DATA_W  from memory read output (combinational)

## Operation
- The FSM has three states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Arbitration happens in IDLE and RESP only.
  - Single requester wins.
  - If both request, the port not in `last` wins.
  - `last` resets to 1, so port 0 wins the first conflict.
- On the arbitration edge:
  - latch winner into `owner`, update `last`
  - load mem_direccion, mem_dato, and pending-we from the winner's inputs
  - go to ACCESS
  - if no requester: IDLE stays IDLE; RESP goes to IDLE.
- ACCESS, exactly one cycle:
  - mem_sel = latched we
  - gnt[owner] = 1
  - on a read, capture mem_salida into rdata at the end of the cycle
  - go to RESP.
- RESP:
  - mem_sel = 0
  - rvalid[owner] = 1 if the access was a read; a write produces no rvalid
  - rdata holds its value until the next read capture
  - arbitrate for the next access.
- A master must drop or replace its request in the cycle after gnt. req sampled in RESP is treated as a new request.
- mem_sel is high only in ACCESS cycles for writes. A read never asserts mem_sel.
- Reset values: gnt0/1 = 0, rvalid0/1 = 0, rdata = 0, mem_sel = 0, mem_dato = 0, mem_direccion = 0, owner = 0, last = 1.

## Timing
- Read latency: request sampled at edge N; gnt during cycle N+1; rvalid + rdata during cycle N+2.
- Write: gnt and the memory write occur in the same cycle, N+1.
- Throughput: one access per 2 cycles sustained, e.g. back-to-back from RESP.
- Both requesting continuously: strict alternation 0,1,0,1… after reset.
- One master requesting continuously while the other is idle: that master is served every 2 cycles. `last` does not block it.
- Reset asserted mid-ACCESS: at the next edge all outputs take reset values and the state is IDLE. No gnt or rvalid is issued afterwards for the aborted access. A write whose ACCESS cycle completed before the reset edge is not undone.
- Address is zero-extended, so it is never out of range.

## Structure
- Shared package/header (`arbitro_defs`):
  - state encodings IDLE=2'd0, ACCESS=2'd1, RESP=2'd2
  - DATA_W / ADDR_W defaults
- One natural sub-module, `rr_arbitro2`: combinational two-way round-robin pick from (req0, req1, last) -> (any, winner). The FSM, request/response registers, and memory-port drive stay in `arbitro_memoria`.

## Test plan
- Reset, then port 0 read addr 5 with memory word 5 = 0xA5A5_0005: gnt0 one cycle after request, then rvalid0 with rdata = 0xA5A5_0005; rvalid1 never asserted.
- Port 1 write 0xDEAD_BEEF to addr 63, then port 0 read addr 63: mem_sel high for exactly one cycle with mem_direccion = 63; the read returns 0xDEAD_BEEF; no rvalid for the write.
- Both ports hold read requests (addr 1, addr 2) for 8 cycles: grants alternate gnt0, gnt1, gnt0, gnt1, spaced 2 cycles apart; each rvalid follows its own gnt by one cycle with the correct data.
- Port 0 sole continuous requester for 6 cycles: gnt0 every 2 cycles, no gaps caused by `last`.
- rst_n dropped during ACCESS of a write to addr 10: next edge gives all outputs 0 and state IDLE; no subsequent gnt/rvalid until a new request; after reset, port 0 wins a simultaneous conflict.
